toggle_cover_drain: RTL and testbench
=====================================

// Module: toggle_cover_drain
// PURPOSE
//  Scheduler that shares one coverage-report channel among WIDTH toggle points.
//  - Captures per-cycle toggle hits into a sticky pending bitmap.
//  - Reports each distinct point once, one per cycle, on a valid/ready port as the global index COVER_INDEX+i.
//  - Used where the per-bit DPI coverage call is unavailable (formal, FPGA); drives a single trace/DPI sink.
// PARAMETERS
//  WIDTH        32   number of toggle points handled by this instance (1..64)
//  COVER_INDEX  0    global index of bit 0 of this instance
//  COVER_TOTAL  28338 total points in the design; elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL
// PORTS
//  clock      in   1      single clock; all state on posedge
//  reset      in   1      asynchronous, active-low reset
//  enable     in   1      1: sample hit; 0: ignore hit (drain continues)
//  clear      in   1      1-cycle pulse: forget covered/pending, re-arm all points
//  hit        in   WIDTH  per-point toggle strobes for this cycle
//  out_valid  out  1      report available
//  out_ready  in   1      sink accepts report when out_valid&&out_ready
//  out_index  out  64     COVER_INDEX + point number
//  hit_count  out  $clog2(WIDTH+1)  distinct points reported-or-pending since reset/clear
//  all_hit    out  1      hit_count == WIDTH
// BEHAVIOUR
//  Reset (reset==0, async): pending=0, covered=0, ptr=0, out_valid=0, out_index=0, hit_count=0, all_hit=0.
//  Capture: new = hit & ~covered when enable&&!clear, else 0.
//   - Each posedge: covered|=new; pending|=new; hit_count+=popcount(new).
//  Grant: load slot free when !out_valid || out_ready.
//   - If slot free and pending!=0: pick first set bit at or after ptr (rotating, wraps WIDTH-1->0).
//   - Load out_index=COVER_INDEX+i, out_valid=1; clear pending[i]; ptr = (i+1)%WIDTH.
//   - If slot free and pending==0: out_valid=0 (out_index holds last value).
//  Grant uses pending as registered at the start of the cycle, not new.
//   - Latency: hit in cycle t -> pending at t+1 -> out_valid at t+2 when idle.
//  Throughput: one report per cycle under out_ready=1; a 32-bit burst drains in 32 cycles.
//  Stall: while out_valid&&!out_ready, out_index/out_valid are held stable; pending keeps accumulating.
//  Duplicates: a point already covered is never re-queued, even if not yet reported.
//  Simultaneous same-bit pick and capture: cannot occur (covered blocks re-entry).
//  clear:
//   - pending, covered, hit_count and ptr go to 0; that cycle's hit is discarded.
//   - A report currently presented stays valid until accepted (no handshake retraction).
//  all_hit is registered (from next hit_count); it stays 1 until reset/clear.
//  hit_count saturates at WIDTH by construction; no wrap.
//  enable=0 with pending!=0: draining continues normally.
// STRUCTURE
//  Package toggle_cover_pkg:
//   - COVER_IDX_W=64 and the cover_index_t typedef.
//   - popcount function.
//   - Shared COVER_TOTAL constant.
//  Sub-module rr_pick #(WIDTH): combinational rotating-priority picker.
//   - Inputs req[WIDTH], ptr.
//   - Outputs gnt_valid, gnt_idx.
//  Top holds the pending/covered/ptr/output registers and the counter.
// TESTING
//  1 Reset, hit=0x1 one cycle, ready=1 -> out_valid in cycle t+2, out_index=COVER_INDEX+0, next cycle out_valid=0, hit_count=1.
//  2 hit=0xFFFFFFFF one cycle, ready=1 -> 32 consecutive reports, indices +0..+31 in order; all_hit=1; then idle.
//  3 hit=0x8000_0001, ready=0 for 5 cycles -> out_index=+0 held stable 5 cycles; release -> +0 then +31.
//  4 hit[3]=1 for 10 cycles -> exactly one report of +3; hit_count=1.
//  5 After case 2, pulse clear with hit=0x4 -> hit discarded, hit_count=0, all_hit=0; next hit=0x4 -> +2 reported again.
//  6 hit=0xFF, accept 3 reports, assert reset mid-drain -> all outputs 0 immediately; no further reports until new hit.

Source files
------------

// File: rtl/toggle_cover_drain_pkg.sv
// Shared types and helpers for the toggle-coverage drain scheduler.
package toggle_cover_pkg;

  localparam int unsigned COVER_IDX_W = 64;
  typedef logic [COVER_IDX_W-1:0] cover_index_t;

  // Total number of toggle points in the whole design.
  localparam int unsigned COVER_TOTAL = 28338;

  // Number of set bits in a vector of up to 64 points.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_cover_drain_if.sv
// Coverage report channel: valid/ready handshake carrying a global point index.
interface toggle_cover_drain_if;
  import toggle_cover_pkg::*;

  logic         valid;
  logic         ready;
  cover_index_t index;

  modport master (output valid, output index, input ready);
  modport slave  (input valid, input index, output ready);

endinterface

// File: rtl/toggle_cover_drain_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned Width = 32,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic             gnt_valid_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  // Scan Width positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < Width; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= Width) idx = idx - Width;
      if (!gnt_valid_o && req_i[idx[IdxW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/toggle_cover_drain.sv
// Shares one coverage report channel among Width toggle points: sticky capture of
// first hits, then one report per cycle in rotating order.
module toggle_cover_drain
  import toggle_cover_pkg::*;
#(
  parameter int unsigned Width      = 32,
  parameter int unsigned CoverIndex = 0,
  parameter int unsigned CoverTotal = COVER_TOTAL
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [Width-1:0]           hit_i,
  toggle_cover_drain_if.master       out_if,
  output logic [$clog2(Width+1)-1:0] hit_count_o,
  output logic                       all_hit_o
);

  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned CntW = $clog2(Width + 1);

  if (Width < 1 || Width > 64) begin : g_bad_width
    $error("toggle_cover_drain: Width must be 1..64");
  end
  if (CoverIndex + Width > CoverTotal) begin : g_bad_range
    $error("toggle_cover_drain: CoverIndex+Width exceeds CoverTotal");
  end

  logic [Width-1:0] pending_q, pending_d;
  logic [Width-1:0] covered_q, covered_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic             valid_q, valid_d;
  cover_index_t     index_q, index_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             all_hit_q, all_hit_d;

  logic [Width-1:0] new_hit;
  logic [63:0]      new_ext;
  logic             slot_free;
  logic             grant;
  logic             gnt_valid;
  logic [IdxW-1:0]  gnt_idx;

  rr_pick #(
    .Width (Width),
    .IdxW  (IdxW)
  ) u_pick (
    .req_i       (pending_q),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Next-state: grant from registered pending, then fold in newly covered points.
  always_comb begin
    pending_d = pending_q;
    covered_d = covered_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    index_d   = index_q;
    count_d   = count_q;

    new_hit = (enable_i && !clear_i) ? (hit_i & ~covered_q) : '0;
    new_ext = '0;
    new_ext[Width-1:0] = new_hit;

    slot_free = !valid_q || out_if.ready;
    // Clearing forgets pending work, so nothing new is loaded that cycle.
    grant = slot_free && gnt_valid && !clear_i;

    if (grant) begin
      pending_d[gnt_idx] = 1'b0;
      valid_d            = 1'b1;
      index_d            = cover_index_t'(CoverIndex) + cover_index_t'(gnt_idx);
      if (int'(gnt_idx) == Width - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + IdxW'(1);
      end
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    pending_d = pending_d | new_hit;
    covered_d = covered_d | new_hit;
    count_d   = count_q + CntW'(popcount(new_ext));

    if (clear_i) begin
      pending_d = '0;
      covered_d = '0;
      count_d   = '0;
      ptr_d     = '0;
    end

    all_hit_d = (count_d == CntW'(Width));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      covered_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      count_q   <= '0;
      all_hit_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      covered_q <= covered_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      count_q   <= count_d;
      all_hit_q <= all_hit_d;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.index = index_q;
  assign hit_count_o  = count_q;
  assign all_hit_o    = all_hit_q;

endmodule

// File: tb/tb_toggle_cover_drain.sv
// Bench for toggle_cover_drain: directed cases plus randomized traffic against a
// set-based reference model.
module tb_toggle_cover_drain;
  import toggle_cover_pkg::*;

  localparam int W    = 32;
  localparam int BASE = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] hit = '0;
  logic [5:0]   hit_count;
  logic         all_hit;

  toggle_cover_drain_if u_if ();

  toggle_cover_drain #(
    .Width      (W),
    .CoverIndex (BASE),
    .CoverTotal (COVER_TOTAL)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .clear_i     (clear),
    .hit_i       (hit),
    .out_if      (u_if.master),
    .hit_count_o (hit_count),
    .all_hit_o   (all_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sets of covered and pending points, rotating pointer.
  bit              m_cov  [W];
  bit              m_pend [W];
  int              m_ptr;
  bit              m_valid;
  longint unsigned m_idx;
  int              m_cnt;
  bit              m_all;

  int              acc_n;
  longint unsigned acc_last;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_cov[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_ptr = 0; m_valid = 1'b0; m_idx = 0; m_cnt = 0; m_all = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] h, input bit en, input bit clr,
                            input bit rdy);
    bit free;
    int g;
    free = !m_valid || rdy;
    g = -1;
    if (clr) begin
      for (int i = 0; i < W; i++) begin
        m_cov[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end
      m_cnt = 0; m_ptr = 0;
      if (free) m_valid = 1'b0;
    end else begin
      if (free) begin
        for (int k = 0; k < W; k++) begin
          int j;
          j = (m_ptr + k) % W;
          if (g < 0 && m_pend[j]) g = j;
        end
        if (g >= 0) begin
          m_pend[g] = 1'b0;
          m_valid = 1'b1;
          m_idx = longint'(BASE + g);
          m_ptr = (g + 1) % W;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (en) begin
        for (int i = 0; i < W; i++) begin
          if (h[i] && !m_cov[i]) begin
            m_cov[i] = 1'b1; m_pend[i] = 1'b1; m_cnt++;
          end
        end
      end
    end
    m_all = (m_cnt == W);
  endtask

  task automatic compare();
    check("out_valid", u_if.valid, m_valid);
    check("out_index", u_if.index, m_idx);
    check("hit_count", hit_count, m_cnt);
    check("all_hit", all_hit, m_all);
  endtask

  // One clock: drive at negedge, advance the model on the edge, compare after it.
  task automatic cyc(input logic [W-1:0] h, input bit en, input bit clr, input bit rdy);
    @(negedge clk);
    hit = h; enable = en; clear = clr; u_if.ready = rdy;
    #1;
    if (u_if.valid && u_if.ready) begin
      acc_n++;
      acc_last = u_if.index;
    end
    @(posedge clk);
    model_step(h, en, clr, rdy);
    #1 compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    hit = '0; enable = 1'b0; clear = 1'b0; u_if.ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 compare();
  endtask

  initial begin
    u_if.ready = 1'b1;
    acc_n = 0; acc_last = 0;
    model_reset();

    // Reset state and single-hit latency.
    do_reset();
    check("rst_valid", u_if.valid, 0);
    check("rst_index", u_if.index, 0);
    cyc(32'h1, 1, 0, 1);
    check("t1_valid_t1", u_if.valid, 0);
    check("t1_count", hit_count, 1);
    cyc('0, 1, 0, 1);
    check("t1_valid_t2", u_if.valid, 1);
    check("t1_index", u_if.index, BASE);
    cyc('0, 1, 0, 1);
    check("t1_valid_after", u_if.valid, 0);
    check("t1_count_after", hit_count, 1);

    // Full burst drains in order.
    do_reset();
    cyc('1, 1, 0, 1);
    check("t2_all_hit", all_hit, 1);
    check("t2_count", hit_count, 32);
    for (int k = 0; k < W; k++) begin
      cyc('0, 1, 0, 1);
      check("t2_burst_valid", u_if.valid, 1);
      check("t2_burst_index", u_if.index, BASE + k);
    end
    cyc('0, 1, 0, 1);
    check("t2_idle", u_if.valid, 0);

    // Clear discards that cycle's hit and re-arms points.
    cyc(32'h4, 1, 1, 1);
    check("t5_count", hit_count, 0);
    check("t5_all_hit", all_hit, 0);
    cyc(32'h4, 1, 0, 1);
    check("t5_count_rearm", hit_count, 1);
    cyc('0, 1, 0, 1);
    check("t5_valid", u_if.valid, 1);
    check("t5_index", u_if.index, BASE + 2);

    // Stall holds the presented report.
    do_reset();
    cyc(32'h8000_0001, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc('0, 1, 0, 0);
      check("t3_hold_valid", u_if.valid, 1);
      check("t3_hold_index", u_if.index, BASE);
    end
    cyc('0, 1, 0, 1);
    check("t3_next_index", u_if.index, BASE + 31);
    cyc('0, 1, 0, 1);
    check("t3_idle", u_if.valid, 0);

    // Repeated hits report once.
    do_reset();
    acc_n = 0;
    repeat (10) cyc(32'h8, 1, 0, 1);
    repeat (3) cyc('0, 1, 0, 1);
    check("t4_reports", acc_n, 1);
    check("t4_index", acc_last, BASE + 3);
    check("t4_count", hit_count, 1);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    acc_n = 0;
    cyc(32'hFF, 1, 0, 1);
    repeat (4) cyc('0, 1, 0, 1);
    check("t6_accepted", acc_n, 3);
    @(negedge clk);
    hit = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", u_if.valid, 0);
    check("t6_rst_index", u_if.index, 0);
    check("t6_rst_count", hit_count, 0);
    check("t6_rst_all", all_hit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      cyc('0, 1, 0, 1);
      check("t6_quiet", u_if.valid, 0);
    end
    cyc(32'h10, 1, 0, 1);
    cyc('0, 1, 0, 1);
    check("t6_new_index", u_if.index, BASE + 4);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] h;
      bit en, clr, rdy;
      h   = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 99) == 0) h = '1;
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(h, en, clr, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
